// File: rtl/mdu_pkg.sv
// Op and FSM encodings plus operand-signedness helpers shared by the mdu_iter slice.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_div(input mdu_op_e op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(input mdu_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input mdu_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step on magnitudes: shift in a dividend bit, trial-subtract, keep or restore.
module mdu_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            bit_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // rem_in < divisor, so the top bit of diff is a clean borrow flag.
    assign shifted = {rem_in, bit_in};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[XLEN];
    assign rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/mdu_iter.sv
// Single-request RV32M-style mul/div: XLEN BUSY cycles (1 for div-by-zero/overflow, and for multiplies
// under MDU_FAST_MUL_EN); result held in DONE until out_ready, in_ready low while busy or holding.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_y,
    output logic [TAG_W-1:0] out_tag,
    input  logic             kill
);
    localparam int               CNT_W     = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        state;
    mdu_op_e           cur_op;
    logic              neg_main;
    logic              neg_rem;
    logic              special;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opb;
    logic [TAG_W-1:0]  tag;

    mdu_op_e         req_op;
    logic            req_sign_a;
    logic            req_sign_b;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN-1:0] special_y;

    always_comb begin
        req_op     = mdu_op_e'(in_op);
        req_sign_a = is_signed_a(req_op) & in_a[XLEN-1];
        req_sign_b = is_signed_b(req_op) & in_b[XLEN-1];
        mag_a      = req_sign_a ? -in_a : in_a;
        mag_b      = req_sign_b ? -in_b : in_b;
        div_zero   = is_div(req_op) && (in_b == '0);
        div_ovf    = is_div(req_op) && is_signed_a(req_op) && (in_a == MOST_NEG) && (in_b == '1);
        // in_op[1] separates REM/REMU from DIV/DIVU
        special_y  = in_op[1] ? in_a : '1;
        if (div_ovf) begin
            special_y = in_op[1] ? '0 : in_a;
        end
    end

    logic [XLEN-1:0] rem_next;
    logic            q_bit;

    mdu_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_in  (acc[2*XLEN-1:XLEN]),
        .bit_in  (acc[XLEN-1]),
        .divisor (opb),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    // acc is {remainder, dividend->quotient} when dividing, {partial sum, multiplier} when multiplying.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] step_next;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   result;
    logic              last;

    always_comb begin
        div_next  = {rem_next, acc[XLEN-2:0], q_bit};
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        step_next = is_div(cur_op) ? div_next : mul_next;
`ifdef MDU_FAST_MUL_EN
        prod = {{XLEN{1'b0}}, acc[XLEN-1:0]} * {{XLEN{1'b0}}, opb};
        last = special || !is_div(cur_op) || (cnt == LAST_STEP);
`else
        prod = mul_next;
        last = special || (cnt == LAST_STEP);
`endif
        prod_signed = neg_main ? -prod : prod;
        quo_fix     = neg_main ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
        rem_fix     = neg_rem ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
        if (special) begin
            result = acc[XLEN-1:0];
        end else if (is_div(cur_op)) begin
            result = cur_op[1] ? rem_fix : quo_fix;
        end else if (cur_op == OP_MUL) begin
            result = prod_signed[XLEN-1:0];
        end else begin
            result = prod_signed[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cur_op   <= OP_MUL;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            special  <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            tag      <= '0;
            out_y    <= '0;
            out_tag  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        cur_op   <= req_op;
                        neg_main <= req_sign_a ^ req_sign_b;
                        neg_rem  <= req_sign_a;
                        special  <= div_zero || div_ovf;
                        acc      <= {{XLEN{1'b0}}, (div_zero || div_ovf) ? special_y : mag_a};
                        opb      <= mag_b;
                        tag      <= in_tag;
                        cnt      <= '0;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (kill) begin
                        state <= ST_IDLE;
                    end else begin
                        acc <= step_next;
                        cnt <= cnt + CNT_W'(1);
                        if (last) begin
                            out_y   <= result;
                            out_tag <= tag;
                            state   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (kill || out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: directed corner cases plus random ops against a plain-arithmetic model.
`timescale 1ns/1ps
module tb_mdu_iter;
    import mdu_pkg::*;

    localparam int XLEN  = 32;
    localparam int TAG_W = 4;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = 3'd0;
    logic [XLEN-1:0]  in_a = '0;
    logic [XLEN-1:0]  in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [XLEN-1:0]  out_y;
    logic [TAG_W-1:0] out_tag;
    logic             kill = 1'b0;

    mdu_iter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_tag   (out_tag),
        .kill      (kill)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] y;
        logic [3:0]  tag;
        int          lat;
        int          acc_cyc;
    } exp_t;
    exp_t sb_q[$];

    int          stall = 0;
    bit          mon_en = 1'b0;
    bit          seen = 1'b0;
    bit          just_acc = 1'b0;
    logic [31:0] hold_y = '0;
    logic [3:0]  hold_tag = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_y(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        logic [63:0]     p = '0;
        logic [31:0]     r = '0;
        bit              ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = ua * ub; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0)   r = 32'hFFFF_FFFF;
                else if (ovf) r = a;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else begin p = ua / ub; r = p[31:0]; end
            end
            3'd6: begin
                if (b == 0)   r = a;
                else if (ovf) r = 32'd0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: begin
                if (b == 0) r = a;
                else begin p = ua % ub; r = p[31:0]; end
            end
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return MUL_LAT;
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input logic [31:0] exp_y, input bit track);
        int   t = 0;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", t);
            in_valid = 1'b0;
            return;
        end
        if (track) begin
            e.y       = exp_y;
            e.tag     = tag;
            e.lat     = model_lat(op, a, b);
            e.acc_cyc = cyc + 1;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb_q.size() != 0 || !in_ready) && t < 500) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (sb_q.size() != 0 || !in_ready) begin
            n_err++;
            $display("FAIL drain_timeout: %0d outstanding, in_ready=%b, required 0 outstanding", sb_q.size(), in_ready);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (just_acc) begin
                check("released_out_valid", 64'(out_valid), 64'd0);
                check("released_in_ready", 64'(in_ready), 64'd1);
                just_acc = 1'b0;
            end
            if (out_valid) begin
                check("done_in_ready", 64'(in_ready), 64'd0);
                if (!seen) begin
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_result: out_y=0x%0h out_tag=0x%0h, required no result", out_y, out_tag);
                    end else begin
                        check("out_y", 64'(out_y), 64'(sb_q[0].y));
                        check("out_tag", 64'(out_tag), 64'(sb_q[0].tag));
                        check("latency", 64'(cyc - sb_q[0].acc_cyc), 64'(sb_q[0].lat));
                    end
                    seen     = 1'b1;
                    hold_y   = out_y;
                    hold_tag = out_tag;
                end else begin
                    check("hold_y", 64'(out_y), 64'(hold_y));
                    check("hold_tag", 64'(out_tag), 64'(hold_tag));
                end
                if (stall > 0) begin
                    out_ready = 1'b0;
                    stall--;
                end else begin
                    out_ready = 1'($urandom_range(0, 1));
                end
                if (out_ready) begin
                    if (sb_q.size() > 0) void'(sb_q.pop_front());
                    seen     = 1'b0;
                    just_acc = 1'b1;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_y", 64'(out_y), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        mon_en = 1'b1;

        issue(OP_DIV,    32'hFFFF_FFF9, 32'd2,        4'h1, 32'hFFFF_FFFD, 1'b1);
        issue(OP_REM,    32'hFFFF_FFF9, 32'd2,        4'h2, 32'hFFFF_FFFF, 1'b1);
        issue(OP_DIVU,   32'd100,       32'd0,        4'h3, 32'hFFFF_FFFF, 1'b1);
        issue(OP_REMU,   32'd100,       32'd0,        4'h4, 32'd100,       1'b1);
        issue(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 4'h5, 32'h8000_0000, 1'b1);
        issue(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 4'h6, 32'd0,        1'b1);
        issue(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h7, 32'd0,        1'b1);
        issue(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h8, 32'hFFFF_FFFE, 1'b1);
        issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h9, 32'hFFFF_FFFF, 1'b1);
        wait_idle();

        stall = 5;
        issue(OP_MUL, 32'd3, 32'd5, 4'hA, 32'd15, 1'b1);
        wait_idle();

        // kill lands on the 10th BUSY cycle of an untracked divide
        issue(OP_DIVU, 32'd1000, 32'd7, 4'hB, 32'd0, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_in_ready", 64'(in_ready), 64'd1);
        check("kill_out_valid", 64'(out_valid), 64'd0);
        issue(OP_MUL, 32'd2, 32'd2, 4'hC, 32'd4, 1'b1);
        wait_idle();

        kill = 1'b1;
        issue(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 4'hD, model_y(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0), 1'b1);
        kill = 1'b0;
        wait_idle();

        issue(OP_DIV, 32'h1234_5678, 32'd3, 4'hE, 32'd0, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_y", 64'(out_y), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (40) @(negedge clk);
        check("midrst_no_result", 64'(out_valid), 64'd0);

        for (int i = 0; i < 60; i++) begin
            op  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            a   = $urandom;
            b   = $urandom;
            if (sel == 0) begin
                b = 32'd0;
            end else if (sel == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (sel == 2) begin
                a = 32'($urandom_range(0, 20)) - 32'd10;
                b = 32'($urandom_range(0, 8)) - 32'd4;
            end
            issue(op, a, b, 4'($urandom_range(0, 15)), model_y(op, a, b), 1'b1);
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (legal: 8..64, even).
REQ-002 SHALL have parameter TAG_W, default 4, width of the pass-through request tag.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  unit can accept request.
REQ-007 SHALL have port in_op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 SHALL have ports in_a, in_b  input  XLEN  operands (rs1, rs2).
REQ-009 SHALL have port in_tag  input  TAG_W  opaque tag, returned with result.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port out_y  output  XLEN  result.
REQ-013 SHALL have port out_tag  output  TAG_W  tag of the request that produced out_y.
REQ-014 SHALL have port kill  input  1  abort in-flight operation.

Function
REQ-015 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE; in_ready = (state==IDLE).
REQ-016 SHALL capture in_op/in_a/in_b/in_tag when in_valid && in_ready, then enter BUSY.
REQ-017 Divide ops SHALL run a restoring divider, one quotient bit per cycle, on operand magnitudes: exactly XLEN BUSY cycles, then DONE.
REQ-018 Multiply ops (REQ-027 absent) SHALL run shift-add, one bit per cycle: exactly XLEN BUSY cycles, then DONE.
REQ-019 MUL SHALL return low XLEN bits of the 2*XLEN product; MULH signed*signed high; MULHSU signed a * unsigned b high; MULHU unsigned high.
REQ-020 DIV/REM SHALL truncate toward zero; REM sign follows dividend.
REQ-021 Divisor==0: DIV/DIVU SHALL return all-ones, REM/REMU SHALL return in_a; 1 BUSY cycle only.
REQ-022 DIV with a = most-negative, b = -1 SHALL return a; REM SHALL return 0; 1 BUSY cycle only.
REQ-023 In DONE, out_valid=1; out_y/out_tag SHALL stay stable until out_valid && out_ready; the accepting cycle returns the FSM to IDLE; no new request is accepted in that same cycle.
REQ-024 kill SHALL force IDLE next cycle from BUSY or DONE and drop the result; kill in IDLE SHALL have no effect; kill with in_valid in IDLE SHALL still accept the request.

Reset
REQ-025 While rst_n=0 at a clock edge: state=IDLE, out_valid=0, out_y=0, out_tag=0, internal counters/accumulators=0; in_ready=1 the cycle after release.
REQ-026 Reset during BUSY or DONE SHALL abandon the operation with no result emitted.

Configuration
REQ-027 Macro MDU_FAST_MUL_EN defined: multiply ops SHALL compute in one combinational product stage (1 BUSY cycle); undefined: iterative per REQ-018. Divide behaviour SHALL be identical either way.

Structure
REQ-028 Package mdu_pkg SHALL hold the op enum (mdu_op_e), FSM state enum, and the helpers is_div/is_signed_a/is_signed_b.
REQ-029 The divider datapath SHALL be sub-module mdu_div_step (one restoring step: partial remainder, divisor -> next remainder, quotient bit); the multiplier stays inline.

Verification
REQ-030 DIV a=-7, b=2 (XLEN=32) -> out_y=0xFFFFFFFD after 32 BUSY cycles; REM same operands -> 0xFFFFFFFF.
REQ-031 DIVU a=100, b=0 -> 0xFFFFFFFF; REMU a=100, b=0 -> 100; each after 1 BUSY cycle.
REQ-032 DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-033 MULH a=0xFFFFFFFF, b=0xFFFFFFFF -> 0; MULHU -> 0xFFFFFFFE; MULHSU -> 0xFFFFFFFF; latency 32 BUSY cycles without MDU_FAST_MUL_EN, 1 with.
REQ-034 MUL 3*5 tag=0xA, out_ready held low 5 cycles -> out_y=15, out_tag=0xA stable, in_ready=0 throughout; accepted on first out_ready=1.
REQ-035 DIVU issued, kill asserted at BUSY cycle 10 -> no out_valid; in_ready=1 next cycle; following MUL 2*2 returns 4.
